// File: rtl/id_char_emitter.sv
// Emits one ASCII identifier per start command: a letter run, a digit run and a
// terminator byte, one byte per valid/ready transfer.
module id_char_emitter #(
   parameter logic [7:0] TERM_CHAR = 8'h2F,
   parameter int         LEN_W     = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [7:0]       alpha_base,
   input  logic [LEN_W-1:0] alpha_len,
   input  logic [7:0]       digit_base,
   input  logic [LEN_W-1:0] digit_len,
   input  logic             ready,
   output logic [7:0]       char,
   output logic             valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ALPHA = 2'd1,
      S_DIGIT = 2'd2,
      S_TERM  = 2'd3
   } state_t;

   localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
   localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

   function automatic logic [7:0] sanitize_alpha(input logic [7:0] c);
      if (((c >= 8'h61) && (c <= 8'h7A)) || ((c >= 8'h41) && (c <= 8'h5A))) begin
         sanitize_alpha = c;
      end else begin
         sanitize_alpha = 8'h61;
      end
   endfunction

   function automatic logic [7:0] sanitize_digit(input logic [7:0] c);
      if ((c >= 8'h30) && (c <= 8'h39)) begin
         sanitize_digit = c;
      end else begin
         sanitize_digit = 8'h30;
      end
   endfunction

   function automatic logic [7:0] next_alpha(input logic [7:0] c);
      if (c == 8'h7A) begin
         next_alpha = 8'h61;
      end else if (c == 8'h5A) begin
         next_alpha = 8'h41;
      end else begin
         next_alpha = c + 8'd1;
      end
   endfunction

   function automatic logic [7:0] next_digit(input logic [7:0] c);
      if (c == 8'h39) begin
         next_digit = 8'h30;
      end else begin
         next_digit = c + 8'd1;
      end
   endfunction

   state_t           state_q, state_d;
   logic [7:0]       char_q, char_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [7:0]       dbase_q, dbase_d;
   logic [LEN_W-1:0] dlen_q, dlen_d;
   logic             xfer_s;

   assign xfer_s = valid_q & ready;

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         char_q  <= 8'h00;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= LEN_ZERO;
         dbase_q <= 8'h30;
         dlen_q  <= LEN_ZERO;
      end else begin
         state_q <= state_d;
         char_q  <= char_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
         dbase_q <= dbase_d;
         dlen_q  <= dlen_d;
      end
   end

   // Next-state decision; zero-length runs are skipped here so the counter never underflows
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (alpha_len != LEN_ZERO) begin
                  state_d = S_ALPHA;
               end else if (digit_len != LEN_ZERO) begin
                  state_d = S_DIGIT;
               end else begin
                  state_d = S_TERM;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_ALPHA: begin
            if (xfer_s && (cnt_q == LEN_ONE)) begin
               state_d = (dlen_q != LEN_ZERO) ? S_DIGIT : S_TERM;
            end else begin
               state_d = S_ALPHA;
            end
         end
         S_DIGIT: begin
            if (xfer_s && (cnt_q == LEN_ONE)) begin
               state_d = S_TERM;
            end else begin
               state_d = S_DIGIT;
            end
         end
         S_TERM: begin
            if (xfer_s) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_TERM;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Next values of the registered outputs, run counter and latched digit config
   always_comb begin
      char_d  = char_q;
      valid_d = valid_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      cnt_d   = cnt_q;
      dbase_d = dbase_q;
      dlen_d  = dlen_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               valid_d = 1'b1;
               busy_d  = 1'b1;
               dbase_d = sanitize_digit(digit_base);
               dlen_d  = digit_len;
               if (alpha_len != LEN_ZERO) begin
                  char_d = sanitize_alpha(alpha_base);
                  cnt_d  = alpha_len;
               end else if (digit_len != LEN_ZERO) begin
                  char_d = sanitize_digit(digit_base);
                  cnt_d  = digit_len;
               end else begin
                  char_d = TERM_CHAR;
                  cnt_d  = LEN_ZERO;
               end
            end else begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
            end
         end
         S_ALPHA: begin
            if (xfer_s) begin
               if (cnt_q != LEN_ONE) begin
                  char_d = next_alpha(char_q);
                  cnt_d  = cnt_q - LEN_ONE;
               end else if (dlen_q != LEN_ZERO) begin
                  char_d = dbase_q;
                  cnt_d  = dlen_q;
               end else begin
                  char_d = TERM_CHAR;
                  cnt_d  = LEN_ZERO;
               end
            end else begin
               char_d = char_q;
            end
         end
         S_DIGIT: begin
            if (xfer_s) begin
               if (cnt_q != LEN_ONE) begin
                  char_d = next_digit(char_q);
                  cnt_d  = cnt_q - LEN_ONE;
               end else begin
                  char_d = TERM_CHAR;
                  cnt_d  = LEN_ZERO;
               end
            end else begin
               char_d = char_q;
            end
         end
         S_TERM: begin
            if (xfer_s) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               done_d  = 1'b1;
            end else begin
               done_d = 1'b0;
            end
         end
         default: begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   assign char  = char_q;
   assign valid = valid_q;
   assign busy  = busy_q;
   assign done  = done_q;

endmodule

// File: doc/id_char_emitter.md
Name: id_char_emitter

Overview:
- Character-stream generator; the transmit-side counterpart of the identifier-recognizing FSM.
- On a start command it emits one ASCII identifier, one byte per accepted transfer, in this order:
  - alpha run (letters);
  - digit run;
  - one terminator byte.
- Feeds the identifier recognizer and the char-stream benches, and acts as a programmable stimulus source.
- Uses a valid/ready handshake so the consumer can stall the stream.

Parameters:
- TERM_CHAR, 8'h2F ("/"): terminator byte emitted after the digit run.
- LEN_W, 4: width of the run-length inputs; maximum run is 2^LEN_W-1 characters.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset_n  input  1  synchronous reset, active-low.
- start  input  1  request a new identifier; honoured only when busy=0.
- alpha_base  input  8  first letter ('a'..'z' or 'A'..'Z').
- alpha_len  input  LEN_W  number of letters.
- digit_base  input  8  first digit ('0'..'9').
- digit_len  input  LEN_W  number of digits.
- ready  input  1  consumer can take char this cycle.
- char  output  8  current ASCII byte.
- valid  output  1  char is meaningful.
- busy  output  1  an identifier is in progress.
- done  output  1  one-cycle pulse after the terminator is accepted.

Behaviour:
- Interface: one clock; reset is synchronous and active-low (clk, reset_n).
- Reset (reset_n=0 at posedge): state=IDLE, char=8'h00, valid=0, busy=0, done=0. This holds even mid-identifier; the partial stream is abandoned with no terminator.
- All outputs are registered.
- Transfer: occurs at a posedge where valid=1 and ready=1.
  - While valid=1 and ready=0, char and valid hold unchanged.
- States: IDLE, ALPHA, DIGIT, TERM.
- IDLE, start=1 at edge:
  - Latch config; set busy=1 and valid=1.
  - Next state: ALPHA if alpha_len>0, else DIGIT if digit_len>0, else TERM.
  - char = the first char of that state. The first char is visible the cycle after the start edge.
- Base sanitising (applied at latch):
  - alpha_base outside 'a'..'z' and 'A'..'Z' -> 'a'.
  - digit_base outside '0'..'9' -> '0'.
- ALPHA:
  - Each transfer advances the letter: 'z'->'a', 'Z'->'A'; case is preserved.
  - After alpha_len transfers: go to DIGIT if digit_len>0, else TERM.
- DIGIT:
  - Each transfer advances the digit, wrapping '9'->'0'.
  - After digit_len transfers: go to TERM.
- TERM:
  - char=TERM_CHAR.
  - On transfer: go to IDLE, valid=0, busy=0, done=1 for exactly one cycle. char is left at TERM_CHAR.
- start while busy=1: ignored, with no effect on the stream or on the latched config.
- start in the done cycle (state is IDLE): accepted normally, so back-to-back identifiers have one bubble cycle (valid=0 for exactly the done cycle).
- Counters: each run uses a down-counter of LEN_W bits loaded from the latched length. No counter ever underflows, because zero-length runs are skipped at the state decision.
- Max latency with ready held 1:
  - start edge to done = alpha_len+digit_len+1 transfers;
  - done asserts one cycle after the last transfer edge.
- Inputs other than start/ready are sampled only on the start-accept edge; later changes are don't-care.

Test Plan:
- Reset, then start with alpha_base="a", alpha_len=4, digit_base="1", digit_len=4, ready=1:
  - expect char sequence "abcd1234/" on 9 consecutive cycles;
  - done=1 on cycle 10;
  - busy=0 from cycle 10.
- alpha_base="y", alpha_len=3, digit_base="8", digit_len=3:
  - expect "yza890/" (both runs wrap).
  - Repeat with alpha_base="Y": expect "YZA890/".
- alpha_len=0, digit_len=2, digit_base="5": expect "56/".
- Both lengths 0: expect only "/" then done.
- alpha_base=8'h21 (invalid) with alpha_len=2: expect "ab".
- Backpressure: "abcd1234/" with ready=0 for 3 cycles while char="c":
  - char holds "c" and valid holds 1;
  - the sequence resumes intact;
  - done is delayed by 3 cycles.
- Mid-stream control:
  - start pulsed while busy: sequence unchanged.
  - reset_n=0 while char="2": next cycle valid=0, busy=0, char=0, done=0.
  - Fresh start afterwards produces the full sequence.
- Back-to-back: start held 1 continuously. Expect two complete identifiers separated by exactly one cycle with valid=0, coincident with done=1.
